// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the load/store initiator: size encodings, FSM states and
// the request legality check used at acceptance.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RMW_WAIT = 3'd2,
        ST_WR       = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // High for misaligned halves/words and for the reserved size code.
    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory port bundle for mem_access_ctrl.
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; the response is a single rsp_valid_o pulse with
// no backpressure, and rsp_err_o/rsp_rdata_o are meaningful only with it.
interface mem_access_ctrl_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        MemRead_o;
    logic        MemWrite_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  mem_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output MemRead_o, MemWrite_o, mem_addr_o, mem_data_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output mem_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  MemRead_o, MemWrite_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Little-endian lane handling: extract+extend for loads, lane merge into the
// previously read word for sub-word stores.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  shift;
    logic [31:0] mask;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        shift     = 5'd0;
        mask      = 32'hFFFF_FFFF;
        load_data = rd_word;
        case (size)
            SZ_BYTE: begin
                shift = {addr_lo, 3'b000};
                mask  = 32'h0000_00FF << shift;
            end
            SZ_HALF: begin
                shift = {addr_lo[1], 4'b0000};
                mask  = 32'h0000_FFFF << shift;
            end
            default: ;
        endcase

        byte_lane = 8'(rd_word >> shift);
        half_lane = 16'(rd_word >> shift);
        if (size == SZ_BYTE) begin
            load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
        end else if (size == SZ_HALF) begin
            load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
        end

        // Word stores take the full mask, so this degenerates to wdata.
        store_data = (rd_word & ~mask) | ((wdata << shift) & mask);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: one request at a time, word-only memory port,
// sub-word loads by lane extraction and sub-word stores by read-modify-write.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    mem_access_ctrl_if.slave   bus,
    output state_t             dbg_state_o
);

    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [3:0]  cnt_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;
    logic [31:0] rsp_rdata_q;

    logic        accept;
    logic        bad_req;
    logic        in_wait;
    logic [31:0] load_data;
    logic [31:0] store_data;

    logic        ready;
    logic        rd_strobe;
    logic        wr_strobe;
    logic        rsp_valid;
    logic        rsp_err;

    assign accept  = (state_q == ST_IDLE) && bus.req_valid_i;
    assign bad_req = is_bad_req(bus.req_size_i, bus.req_addr_i[1:0]);
    assign in_wait = (state_q == ST_RD_WAIT) || (state_q == ST_RMW_WAIT);

    mem_lane_align u_lane_align (
        .rd_word     (bus.mem_data_i),
        .wdata       (wdata_q),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .store_data  (store_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    if (bad_req) begin
                        state_d = ST_RESP;
                    end else if (!bus.req_we_i) begin
                        state_d = ST_RD_WAIT;
                    end else if (bus.req_size_i == SZ_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_WAIT;
                    end
                end
            end
            ST_RD_WAIT:  if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RMW_WAIT: if (cnt_q == 4'd0) state_d = ST_WR;
            ST_WR:       state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        ready     = (state_q == ST_IDLE);
        rd_strobe = in_wait;
        wr_strobe = (state_q == ST_WR);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = (state_q == ST_RESP) && err_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            addr_lo_q   <= 2'b00;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            rsp_rdata_q <= '0;
        end else if (accept) begin
            size_q      <= bus.req_size_i;
            uns_q       <= bus.req_unsigned_i;
            addr_lo_q   <= bus.req_addr_i[1:0];
            wdata_q     <= bus.req_wdata_i;
            err_q       <= bad_req;
            cnt_q       <= CNT_INIT;
            rsp_rdata_q <= '0;
            if (!bad_req) begin
                mem_addr_q <= {bus.req_addr_i[31:2], 2'b00};
                if (bus.req_we_i && (bus.req_size_i == SZ_WORD)) begin
                    mem_data_q <= bus.req_wdata_i;
                end
            end
        end else if (in_wait) begin
            if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end else if (state_q == ST_RD_WAIT) begin
                rsp_rdata_q <= load_data;
            end else begin
                mem_data_q <= store_data;
            end
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.MemRead_o   = rd_strobe;
    assign bus.MemWrite_o  = wr_strobe;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_data_o  = mem_data_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and small randomized checks of mem_access_ctrl at RD_LAT=1 and
// RD_LAT=3, each DUT backed by its own word-addressed memory model.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n, rst3_n;
    mem_access_ctrl_if if1();
    mem_access_ctrl_if if3();
    state_t st1, st3;

    mem_access_ctrl #(.RD_LAT(1)) dut1 (.clk_i(clk), .rst_n_i(rst1_n), .bus(if1), .dbg_state_o(st1));
    mem_access_ctrl #(.RD_LAT(3)) dut3 (.clk_i(clk), .rst_n_i(rst3_n), .bus(if3), .dbg_state_o(st3));

    int          sel = 0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic [31:0] mem1 [64] = '{default: '0};
    logic [31:0] mem3 [64] = '{default: '0};
    logic [31:0] ref1 [64] = '{default: '0};
    logic        pl_en = 1'b0;
    int          pl_sel = 0;
    logic [31:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    assign if1.req_valid_i    = req_valid && (sel == 0);
    assign if3.req_valid_i    = req_valid && (sel == 1);
    assign if1.req_we_i       = req_we;
    assign if3.req_we_i       = req_we;
    assign if1.req_size_i     = req_size;
    assign if3.req_size_i     = req_size;
    assign if1.req_unsigned_i = req_uns;
    assign if3.req_unsigned_i = req_uns;
    assign if1.req_addr_i     = req_addr;
    assign if3.req_addr_i     = req_addr;
    assign if1.req_wdata_i    = req_wdata;
    assign if3.req_wdata_i    = req_wdata;
    assign if1.mem_data_i     = mem1[if1.mem_addr_o[7:2]];
    assign if3.mem_data_i     = mem3[if3.mem_addr_o[7:2]];

    wire        ready_m = (sel == 0) ? if1.req_ready_o : if3.req_ready_o;
    wire        rd_m    = (sel == 0) ? if1.MemRead_o   : if3.MemRead_o;
    wire        wr_m    = (sel == 0) ? if1.MemWrite_o  : if3.MemWrite_o;
    wire        rv_m    = (sel == 0) ? if1.rsp_valid_o : if3.rsp_valid_o;
    wire        err_m   = (sel == 0) ? if1.rsp_err_o   : if3.rsp_err_o;
    wire [31:0] rdata_m = (sel == 0) ? if1.rsp_rdata_o : if3.rsp_rdata_o;
    wire [31:0] addr_m  = (sel == 0) ? if1.mem_addr_o  : if3.mem_addr_o;
    wire [31:0] wdata_m = (sel == 0) ? if1.mem_data_o  : if3.mem_data_o;

    always @(posedge clk) begin
        if (if1.MemWrite_o) mem1[if1.mem_addr_o[7:2]] <= if1.mem_data_o;
        if (if3.MemWrite_o) mem3[if3.mem_addr_o[7:2]] <= if3.mem_data_o;
        if (pl_en) begin
            if (pl_sel == 0) mem1[pl_addr[7:2]] <= pl_data;
            else             mem3[pl_addr[7:2]] <= pl_data;
        end
    end

    typedef struct {
        int          rsp_cyc;
        int          rd_first;
        int          rd_last;
        int          wr_cyc;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        bad;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input int s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_sel = s; pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
        if (s == 0) ref1[a[7:2]] = d;
    endtask

    task automatic run_req(input int s, input logic we, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd, output obs_t o);
        bit got_ready = 1'b0;
        o.rsp_cyc = -1; o.rd_first = -1; o.rd_last = -1; o.wr_cyc = -1;
        o.rdata = '0; o.err = 1'b0; o.rd_addr = '0; o.wr_addr = '0; o.wr_data = '0; o.bad = 1'b0;
        sel = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready_m) begin
                got_ready = 1'b1;
                break;
            end
        end
        check("ready_wait", 32'(got_ready), 32'd1);
        if (!got_ready) return;
        req_we = we; req_size = sz; req_uns = un; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready_m) o.bad = 1'b1;
            if (rd_m && wr_m) o.bad = 1'b1;
            if (rd_m) begin
                if (o.rd_first < 0) begin
                    o.rd_first = k;
                    o.rd_addr  = addr_m;
                end else if (addr_m !== o.rd_addr) begin
                    o.bad = 1'b1;
                end
                o.rd_last = k;
            end
            if (wr_m) begin
                if (o.wr_cyc >= 0) o.bad = 1'b1;
                o.wr_cyc  = k;
                o.wr_addr = addr_m;
                o.wr_data = wdata_m;
            end
            if (rv_m) begin
                if (rd_m || wr_m) o.bad = 1'b1;
                o.rsp_cyc = k;
                o.rdata   = rdata_m;
                o.err     = err_m;
                break;
            end
        end
    endtask

    task automatic expect_obs(input string tag, input obs_t o, input int rsp, input int rdf,
                              input int rdl, input int wr, input logic [31:0] rdata, input logic err);
        check({tag, ".rsp_cyc"}, 32'(o.rsp_cyc), 32'(rsp));
        check({tag, ".rd_first"}, 32'(o.rd_first), 32'(rdf));
        check({tag, ".rd_last"}, 32'(o.rd_last), 32'(rdl));
        check({tag, ".wr_cyc"}, 32'(o.wr_cyc), 32'(wr));
        check({tag, ".rdata"}, o.rdata, rdata);
        check({tag, ".err"}, 32'(o.err), 32'(err));
        check({tag, ".protocol"}, 32'(o.bad), 32'd0);
    endtask

    function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01) return a[0];
        if (sz == 2'b10) return a[1] | a[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input logic un);
        logic [31:0] r;
        if (sz == 2'b00) begin
            r = {24'd0, w[8*a[1:0] +: 8]};
            if (!un && r[7]) r[31:8] = '1;
        end else if (sz == 2'b01) begin
            r = {16'd0, w[16*a[1] +: 16]};
            if (!un && r[15]) r[31:16] = '1;
        end else begin
            r = w;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r = w;
        int base = (sz == 2'b00) ? int'(a[1:0]) : ((sz == 2'b01) ? 2 * int'(a[1]) : 0);
        int n    = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        for (int i = 0; i < n; i++) r[8*(base+i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    initial begin
        obs_t o;
        logic        we, un, bad;
        logic [1:0]  sz;
        logic [31:0] a, d, w, exp_w;
        bit          wr_seen, rsp_seen;
        int          nbad;

        rst1_n = 1'b0;
        rst3_n = 1'b0;
        #2;
        check("rst.ready", 32'(if1.req_ready_o), 32'd1);
        check("rst.memread", 32'(if1.MemRead_o), 32'd0);
        check("rst.memwrite", 32'(if1.MemWrite_o), 32'd0);
        check("rst.rsp_valid", 32'(if1.rsp_valid_o), 32'd0);
        check("rst.rsp_err", 32'(if1.rsp_err_o), 32'd0);
        check("rst.rsp_rdata", if1.rsp_rdata_o, 32'd0);
        check("rst.mem_addr", if1.mem_addr_o, 32'd0);
        check("rst.mem_data", if1.mem_data_o, 32'd0);
        check("rst.state", 32'(st1), 32'(ST_IDLE));
        repeat (3) @(negedge clk);
        rst1_n = 1'b1;
        rst3_n = 1'b1;

        // word store then word load, RD_LAT=1
        run_req(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, o);
        expect_obs("wst10", o, 2, -1, -1, 1, 32'd0, 1'b0);
        check("wst10.addr", o.wr_addr, 32'h10);
        check("wst10.data", o.wr_data, 32'hDEADBEEF);
        ref1[4] = 32'hDEADBEEF;
        run_req(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, o);
        expect_obs("wld10", o, 2, 1, 1, -1, 32'hDEADBEEF, 1'b0);
        check("wld10.addr", o.rd_addr, 32'h10);

        // byte store read-modify-write
        preload(0, 32'h20, 32'h11223344);
        run_req(0, 1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h000000AA, o);
        expect_obs("bst22", o, 3, 1, 1, 2, 32'd0, 1'b0);
        check("bst22.addr", o.wr_addr, 32'h20);
        check("bst22.data", o.wr_data, 32'h11AA3344);
        ref1[8] = 32'h11AA3344;

        // lane extraction and extension
        preload(0, 32'h30, 32'h80FF7F01);
        run_req(0, 1'b0, SZ_BYTE, 1'b0, 32'h31, 32'h0, o);
        expect_obs("lbs31", o, 2, 1, 1, -1, 32'h0000007F, 1'b0);
        run_req(0, 1'b0, SZ_BYTE, 1'b0, 32'h32, 32'h0, o);
        expect_obs("lbs32", o, 2, 1, 1, -1, 32'hFFFFFFFF, 1'b0);
        run_req(0, 1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0, o);
        expect_obs("lhu32", o, 2, 1, 1, -1, 32'h000080FF, 1'b0);
        run_req(0, 1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0, o);
        expect_obs("lhs32", o, 2, 1, 1, -1, 32'hFFFF80FF, 1'b0);
        run_req(0, 1'b0, SZ_BYTE, 1'b1, 32'h33, 32'h0, o);
        expect_obs("lbu33", o, 2, 1, 1, -1, 32'h00000080, 1'b0);

        // error requests: no strobes, response in cycle 1
        run_req(0, 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, o);
        expect_obs("err_h13", o, 1, -1, -1, -1, 32'd0, 1'b1);
        run_req(0, 1'b1, SZ_WORD, 1'b0, 32'h06, 32'h12345678, o);
        expect_obs("err_w06", o, 1, -1, -1, -1, 32'd0, 1'b1);
        run_req(0, 1'b0, SZ_ILL, 1'b0, 32'h00, 32'h0, o);
        expect_obs("err_ill", o, 1, -1, -1, -1, 32'd0, 1'b1);

        // RD_LAT=3 store aborted by reset during cycle 2
        preload(1, 32'h40, 32'hCAFEF00D);
        sel = 1;
        @(negedge clk);
        check("abort.ready", 32'(if3.req_ready_o), 32'd1);
        req_we = 1'b1; req_size = SZ_BYTE; req_uns = 1'b0; req_addr = 32'h41; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort.rd_c1", 32'(if3.MemRead_o), 32'd1);
        @(posedge clk);
        #2 rst3_n = 1'b0;
        #1;
        check("abort.rd_async", 32'(if3.MemRead_o), 32'd0);
        check("abort.wr_async", 32'(if3.MemWrite_o), 32'd0);
        wr_seen = 1'b0;
        rsp_seen = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 2) rst3_n = 1'b1;
            if (if3.MemWrite_o) wr_seen = 1'b1;
            if (if3.rsp_valid_o) rsp_seen = 1'b1;
        end
        check("abort.no_write", 32'(wr_seen), 32'd0);
        check("abort.no_rsp", 32'(rsp_seen), 32'd0);
        check("abort.mem", mem3[16], 32'hCAFEF00D);
        check("abort.ready_after", 32'(if3.req_ready_o), 32'd1);

        // RD_LAT=3 latency
        run_req(1, 1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0, o);
        expect_obs("l3_lb41", o, 4, 1, 3, -1, 32'hFFFFFFF0, 1'b0);
        run_req(1, 1'b1, SZ_HALF, 1'b0, 32'h42, 32'h00001234, o);
        expect_obs("l3_sh42", o, 5, 1, 3, 4, 32'd0, 1'b0);
        check("l3_sh42.data", o.wr_data, 32'h1234F00D);
        run_req(1, 1'b0, SZ_WORD, 1'b1, 32'h40, 32'h0, o);
        expect_obs("l3_lw40", o, 4, 1, 3, -1, 32'h1234F00D, 1'b0);

        // randomized mix against the reference memory, upper half of the map
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'h80 + 32'($urandom_range(0, 127));
            d  = $urandom;
            bad = model_bad(sz, a);
            w = ref1[a[7:2]];
            run_req(0, we, sz, un, a, d, o);
            if (bad) begin
                expect_obs("rnd_err", o, 1, -1, -1, -1, 32'd0, 1'b1);
            end else if (!we) begin
                expect_obs("rnd_ld", o, 2, 1, 1, -1, model_load(w, a, sz, un), 1'b0);
            end else begin
                exp_w = model_merge(w, a, sz, d);
                if (sz == SZ_WORD) expect_obs("rnd_sw", o, 2, -1, -1, 1, 32'd0, 1'b0);
                else               expect_obs("rnd_ss", o, 3, 1, 1, 2, 32'd0, 1'b0);
                check("rnd_st.addr", o.wr_addr, {a[31:2], 2'b00});
                check("rnd_st.data", o.wr_data, exp_w);
                ref1[a[7:2]] = exp_w;
            end
        end
        @(negedge clk);
        nbad = 0;
        for (int i = 0; i < 64; i++) if (mem1[i] !== ref1[i]) nbad++;
        check("mem_final", 32'(nbad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
